// File: rtl/plab5_mcore_domain_mem_responder.sv
// Memory-side endpoint of the split control/data memory network.
// Accepts {type, opaque, addr, len} + data + domain requests, performs a
// byte-lane read or write on a domain-partitioned word array, and returns
// the response through a 2-entry FIFO so the network sees a registered,
// back-pressurable source.
module plab5_mcore_domain_mem_responder #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_num_entries      = 256,
    localparam int O   = p_mem_opaque_nbits,
    localparam int A   = p_mem_addr_nbits,
    localparam int D   = p_mem_data_nbits,
    localparam int NB  = D / 8,
    localparam int L   = $clog2(NB),
    localparam int K   = $clog2(p_num_entries),
    localparam int CW  = 3 + O + A + L,
    localparam int RCW = 3 + O + L
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic [CW-1:0]  req_msg_control,
    input  logic [D-1:0]   req_msg_data,
    input  logic           req_domain,
    input  logic           req_val,
    output logic           req_rdy,
    output logic [RCW-1:0] resp_msg_control,
    output logic [D-1:0]   resp_msg_data,
    output logic           resp_domain,
    output logic           resp_val,
    input  logic           resp_rdy
);

    localparam int EW = RCW + D + 1;

    // Request field decode
    logic [2:0]   req_type;
    logic [O-1:0] req_opaque;
    logic [A-1:0] req_addr;
    logic [L-1:0] req_len;

    assign req_type   = req_msg_control[CW-1 -: 3];
    assign req_opaque = req_msg_control[L+A +: O];
    assign req_addr   = req_msg_control[L +: A];
    assign req_len    = req_msg_control[0 +: L];

    // Address bits above the array index never take part in the access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[A-1:L+K+1];

    logic is_read;
    logic is_write;
    assign is_read  = (req_type == 3'd0);
    assign is_write = (req_type == 3'd1) || (req_type == 3'd2);

    // Handshakes; nothing is accepted or dequeued while reset is held.
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       head_reg;
    logic       head_next;
    logic       tail_reg;
    logic       tail_next;
    logic       req_fire;
    logic       resp_fire;

    assign req_rdy   = (count_reg < 2'd2);
    assign resp_val  = (count_reg != 2'd0);
    assign req_fire  = req_val && req_rdy && !reset;
    assign resp_fire = resp_val && resp_rdy && !reset;

    // Word array: domain bit on top in partitioned mode, plain address
    // bits in shared mode, so a partitioned domain cannot reach the other half.
    logic [D-1:0] mem [0:2*p_num_entries-1];
    logic [K:0]   mem_idx;
    logic [D-1:0] mem_word;

    assign mem_idx  = mode ? {req_domain, req_addr[L +: K]} : req_addr[L +: K+1];
    // The read is combinational: the response enters the queue on the
    // accepting edge, which is what gives the one-cycle response latency.
    assign mem_word = mem[mem_idx];

    // Byte-lane geometry: len==0 means a full word starting at the offset.
    logic [L-1:0] byte_off;
    logic [L:0]   nbytes;
    logic [L+1:0] lane_end;
    logic [D-1:0] wr_shifted;
    logic [D-1:0] rd_shifted;
    logic [D-1:0] rd_data;
    logic [NB-1:0] wr_lane_en;

    assign byte_off   = req_addr[L-1:0];
    assign nbytes     = (req_len == '0) ? (L+1)'(NB) : {1'b0, req_len};
    assign lane_end   = (L+2)'(byte_off) + (L+2)'(nbytes);
    assign wr_shifted = req_msg_data << {byte_off, 3'b000};
    assign rd_shifted = mem_word >> {byte_off, 3'b000};

    // Lanes past the top of the word are simply never enabled (no wrap);
    // read lanes beyond len are zeroed.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign wr_lane_en[gi] = ((L+2)'(gi) >= (L+2)'(byte_off)) &&
                                ((L+2)'(gi) < lane_end);
        assign rd_data[8*gi +: 8] = ((L+1)'(gi) < nbytes) ? rd_shifted[8*gi +: 8] : 8'h00;
    end

    // Byte-enabled array write, committed at the accepting edge
    always_ff @(posedge clk) begin
        if (req_fire && is_write) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_lane_en[i]) begin
                    mem[mem_idx][8*i +: 8] <= wr_shifted[8*i +: 8];
                end
            end
        end
    end

    // Response entry; writes and unknown types return zero data.
    logic [D-1:0]  resp_data_new;
    logic [EW-1:0] new_entry;

    assign resp_data_new = is_read ? rd_data : '0;
    assign new_entry     = {req_type, req_opaque, req_len, resp_data_new, req_domain};

    // Two-entry response FIFO storage (contents need no reset)
    logic [EW-1:0] q_mem [0:1];

    // Enqueue the response of every accepted request
    always_ff @(posedge clk) begin
        if (req_fire) begin
            q_mem[tail_reg] <= new_entry;
        end
    end

    // Pointer and occupancy next-state
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (req_fire) begin
            tail_next = ~tail_reg;
        end
        if (resp_fire) begin
            head_next = ~head_reg;
        end
        case ({req_fire, resp_fire})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; reset drops any queued responses
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign {resp_msg_control, resp_msg_data, resp_domain} = q_mem[head_reg];

endmodule
